// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-through, no-write-allocate data cache between one LSU
//   request channel and one memory-controller consumer channel. Both sides use
//   the level-valid / pulse-ready handshake. One data word per line.
//
//   Parameters
//     ADDR_BITS  address width
//     DATA_BITS  data word width
//     LINES      line count (power of two, >= 2); index = addr[log2(LINES)-1:0]
//
//   Ports
//     clk, reset          clock (rising edge), asynchronous active-high reset
//     flush               invalidate all lines (deferred to IDLE when busy)
//     lsu_read_*          load request in / one-cycle ready pulse + data out
//     lsu_write_*         store request in / one-cycle ready pulse out
//     mem_read_*          fill request out / ready + data in
//     mem_write_*         write-through request out / ready in
//     hit_count,
//     miss_count          16-bit saturating load hit/miss counters, present
//                         only when DCACHE_STATS_EN is defined
//
//   Optional feature macro: DCACHE_STATS_EN
//
//   Every output is a register; nothing combinational reaches the ports.
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int LINES     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,

    input  logic                 lsu_read_valid,
    input  logic [ADDR_BITS-1:0] lsu_read_address,
    output logic                 lsu_read_ready,
    output logic [DATA_BITS-1:0] lsu_read_data,

    input  logic                 lsu_write_valid,
    input  logic [ADDR_BITS-1:0] lsu_write_address,
    input  logic [DATA_BITS-1:0] lsu_write_data,
    output logic                 lsu_write_ready,

    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,

    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    typedef enum logic [2:0] {IDLE, FILL, WRITE, RESPOND, RELEASE} state_t;

    // Request captured at acceptance; wr selects which LSU channel is served.
    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } req_t;

    state_t state_q, state_d;
    req_t   req_q, req_d;

    logic [LINES-1:0]                line_vld_q;
    logic [LINES-1:0][TAG_BITS-1:0]  line_tag_q;
    logic [LINES-1:0][DATA_BITS-1:0] line_dat_q;

    logic flush_pend_q, flush_pend_d;

    // Next values of the registered outputs.
    logic                 rd_rdy_d, wr_rdy_d;
    logic [DATA_BITS-1:0] rd_dat_d;
    logic                 mrd_vld_d, mwr_vld_d;
    logic [ADDR_BITS-1:0] mrd_addr_d, mwr_addr_d;
    logic [DATA_BITS-1:0] mwr_dat_d;

    // Line-array controls.
    logic line_fill, line_upd, flush_now;

    // Lookup for an incoming load, and for the captured store.
    logic [IDX_BITS-1:0] rd_idx, req_idx;
    logic [TAG_BITS-1:0] rd_tag, req_tag;
    logic                rd_hit, req_hit;

    assign rd_idx  = lsu_read_address[IDX_BITS-1:0];
    assign rd_tag  = lsu_read_address[ADDR_BITS-1:IDX_BITS];
    assign req_idx = req_q.addr[IDX_BITS-1:0];
    assign req_tag = req_q.addr[ADDR_BITS-1:IDX_BITS];
    assign rd_hit  = line_vld_q[rd_idx]  && (line_tag_q[rd_idx]  == rd_tag);
    assign req_hit = line_vld_q[req_idx] && (line_tag_q[req_idx] == req_tag);

    // ---------------------------------------------------------------- FSM reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------- next state / outputs
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        flush_pend_d = flush_pend_q;
        rd_rdy_d     = 1'b0;
        wr_rdy_d     = 1'b0;
        rd_dat_d     = lsu_read_data;
        mrd_vld_d    = mem_read_valid;
        mrd_addr_d   = mem_read_address;
        mwr_vld_d    = mem_write_valid;
        mwr_addr_d   = mem_write_address;
        mwr_dat_d    = mem_write_data;
        line_fill    = 1'b0;
        line_upd     = 1'b0;
        flush_now    = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    // Flush owns this cycle; requests wait until the next one.
                    flush_now = 1'b1;
                end else if (lsu_write_valid) begin
                    req_d      = '{wr: 1'b1, addr: lsu_write_address, data: lsu_write_data};
                    mwr_vld_d  = 1'b1;
                    mwr_addr_d = lsu_write_address;
                    mwr_dat_d  = lsu_write_data;
                    state_d    = WRITE;
                end else if (lsu_read_valid) begin
                    req_d = '{wr: 1'b0, addr: lsu_read_address, data: '0};
                    if (rd_hit) begin
                        rd_rdy_d = 1'b1;
                        rd_dat_d = line_dat_q[rd_idx];
                        state_d  = RESPOND;
                    end else begin
                        mrd_vld_d  = 1'b1;
                        mrd_addr_d = lsu_read_address;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_read_ready) begin
                    mrd_vld_d = 1'b0;
                    line_fill = 1'b1;
                    rd_rdy_d  = 1'b1;
                    rd_dat_d  = mem_read_data;
                    state_d   = RESPOND;
                end
            end
            WRITE: begin
                if (mem_write_ready) begin
                    mwr_vld_d = 1'b0;
                    line_upd  = req_hit;   // no allocation on a store miss
                    wr_rdy_d  = 1'b1;
                    state_d   = RESPOND;
                end
            end
            RESPOND: state_d = RELEASE;
            RELEASE: begin
                // Hold off until the served request is withdrawn so a
                // still-asserted valid is not taken as a second request.
                if (req_q.wr ? !lsu_write_valid : !lsu_read_valid) begin
                    state_d   = IDLE;
                    flush_now = flush_pend_q | flush;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_now)
            flush_pend_d = 1'b0;
        else if (flush && state_q != IDLE)
            flush_pend_d = 1'b1;
    end

    // ---------------------------------------------- datapath and output regs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q             <= '0;
            flush_pend_q      <= 1'b0;
            line_vld_q        <= '0;
            line_tag_q        <= '0;
            line_dat_q        <= '0;
            lsu_read_ready    <= 1'b0;
            lsu_read_data     <= '0;
            lsu_write_ready   <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else begin
            req_q             <= req_d;
            flush_pend_q      <= flush_pend_d;
            lsu_read_ready    <= rd_rdy_d;
            lsu_read_data     <= rd_dat_d;
            lsu_write_ready   <= wr_rdy_d;
            mem_read_valid    <= mrd_vld_d;
            mem_read_address  <= mrd_addr_d;
            mem_write_valid   <= mwr_vld_d;
            mem_write_address <= mwr_addr_d;
            mem_write_data    <= mwr_dat_d;

            // flush_now only fires in IDLE or on IDLE entry, never together
            // with a fill or store update, so these writes cannot collide.
            if (flush_now)
                line_vld_q <= '0;
            if (line_fill) begin
                line_vld_q[req_idx] <= 1'b1;
                line_tag_q[req_idx] <= req_tag;
                line_dat_q[req_idx] <= mem_read_data;
            end
            if (line_upd)
                line_dat_q[req_idx] <= req_q.data;
        end
    end

`ifdef DCACHE_STATS_EN
    // A load is classified in the IDLE cycle that accepts it; stores and
    // flush cycles are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (flush_now) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == IDLE && !lsu_write_valid && lsu_read_valid) begin
            if (rd_hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (!rd_hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
//   Directed bench for data_cache (ADDR_BITS=8, DATA_BITS=8, LINES=16).
//   A memory-controller model answers fills and write-throughs after a fixed
//   delay and counts request bursts; loads/stores are issued by tasks that
//   drive on the falling edge and sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_cache;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic       lsu_read_valid, lsu_read_ready;
    logic [7:0] lsu_read_address, lsu_read_data;
    logic       lsu_write_valid, lsu_write_ready;
    logic [7:0] lsu_write_address, lsu_write_data;
    logic       mem_read_valid, mem_read_ready;
    logic [7:0] mem_read_address, mem_read_data;
    logic       mem_write_valid, mem_write_ready;
    logic [7:0] mem_write_address, mem_write_data;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    data_cache #(.ADDR_BITS(8), .DATA_BITS(8), .LINES(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .lsu_read_valid    (lsu_read_valid),
        .lsu_read_address  (lsu_read_address),
        .lsu_read_ready    (lsu_read_ready),
        .lsu_read_data     (lsu_read_data),
        .lsu_write_valid   (lsu_write_valid),
        .lsu_write_address (lsu_write_address),
        .lsu_write_data    (lsu_write_data),
        .lsu_write_ready   (lsu_write_ready),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------- memory model
    logic [7:0] mem [256];
    int         rd_bursts, wr_bursts, rd_dly, wr_dly;
    logic [7:0] last_wa, last_wd;

    initial begin
        mem_read_ready  = 1'b0;
        mem_read_data   = '0;
        mem_write_ready = 1'b0;
        rd_bursts = 0; wr_bursts = 0; rd_dly = 0; wr_dly = 0;
        last_wa = '0; last_wd = '0;
        forever begin
            @(negedge clk);
            mem_read_ready  = 1'b0;
            mem_write_ready = 1'b0;
            if (!mem_read_valid) rd_dly = 0;
            else begin
                if (rd_dly == 0) rd_bursts++;
                rd_dly++;
                if (rd_dly == 3) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem[mem_read_address];
                    rd_dly = 0;
                end
            end
            if (!mem_write_valid) wr_dly = 0;
            else begin
                if (wr_dly == 0) wr_bursts++;
                wr_dly++;
                if (wr_dly == 3) begin
                    mem_write_ready = 1'b1;
                    mem[mem_write_address] = mem_write_data;
                    last_wa = mem_write_address;
                    last_wd = mem_write_data;
                    wr_dly = 0;
                end
            end
        end
    end

    // ------------------------------------------------------- LSU drivers
    int extra;   // ready pulses seen while the request was held past ready

    task automatic ldr(input logic [7:0] a, input int hold, input bit fl,
                       output logic [7:0] d, output int lat);
        int n;
        bit got;
        n = 0; got = 1'b0; d = '0; lat = 0;
        @(negedge clk);
        lsu_read_valid = 1'b1; lsu_read_address = a;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            flush = fl && (n == 1);   // one-cycle flush while the fill is pending
            if (lsu_read_ready) begin
                got = 1'b1; d = lsu_read_data; lat = n;
            end
        end
        flush = 1'b0;
        if (!got) chk("ld_timeout", 32'd0, 32'd1);
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (lsu_read_ready) extra++;
        end
        lsu_read_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic str(input logic [7:0] a, input logic [7:0] v);
        int n;
        bit got;
        n = 0; got = 1'b0;
        @(negedge clk);
        lsu_write_valid = 1'b1; lsu_write_address = a; lsu_write_data = v;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (lsu_write_ready) got = 1'b1;
        end
        if (!got) chk("st_timeout", 32'd0, 32'd1);
        lsu_write_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------- directed test
    initial begin
        logic [7:0] d;
        int lat, b, n;
        bit got, rd_early;

        reset = 1'b1; flush = 1'b0;
        lsu_read_valid = 1'b0;  lsu_read_address = '0;
        lsu_write_valid = 1'b0; lsu_write_address = '0; lsu_write_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'd42;
        mem[2] = 8'd55;

        repeat (3) @(negedge clk);
        chk("rst_lsu_rd_rdy", 32'(lsu_read_ready), 32'd0);
        chk("rst_lsu_wr_rdy", 32'(lsu_write_ready), 32'd0);
        chk("rst_lsu_rd_dat", 32'(lsu_read_data), 32'd0);
        chk("rst_mem_rd_vld", 32'(mem_read_valid), 32'd0);
        chk("rst_mem_wr_vld", 32'(mem_write_valid), 32'd0);
        chk("rst_mem_rd_adr", 32'(mem_read_address), 32'd0);
        reset = 1'b0;

        // Repeated loads of address 0: one fill, then two 1-cycle hits.
        b = rd_bursts; ldr(8'd0, 0, 1'b0, d, lat);
        chk("ld0_data", 32'(d), 32'd42);
        chk("ld0_fills", 32'(rd_bursts - b), 32'd1);
        for (int k = 0; k < 2; k++) begin
            b = rd_bursts; ldr(8'd0, 0, 1'b0, d, lat);
            chk("ld0_hit_data", 32'(d), 32'd42);
            chk("ld0_hit_lat", 32'(lat), 32'd1);
            chk("ld0_hit_fills", 32'(rd_bursts - b), 32'd0);
        end
`ifdef DCACHE_STATS_EN
        chk("stat_hits", 32'(hit_count), 32'd2);
        chk("stat_miss", 32'(miss_count), 32'd1);
`endif

        // Store hit: write-through and line update.
        b = wr_bursts; str(8'd0, 8'd99);
        chk("st0_writes", 32'(wr_bursts - b), 32'd1);
        chk("st0_addr", 32'(last_wa), 32'd0);
        chk("st0_data", 32'(last_wd), 32'd99);
        b = rd_bursts; ldr(8'd0, 0, 1'b0, d, lat);
        chk("ld0_upd_data", 32'(d), 32'd99);
        chk("ld0_upd_lat", 32'(lat), 32'd1);
        chk("ld0_upd_fills", 32'(rd_bursts - b), 32'd0);

        // Store miss allocates nothing.
        b = wr_bursts; str(8'd5, 8'd7);
        chk("st5_writes", 32'(wr_bursts - b), 32'd1);
        b = rd_bursts; ldr(8'd5, 0, 1'b0, d, lat);
        chk("ld5_data", 32'(d), 32'd7);
        chk("ld5_fills", 32'(rd_bursts - b), 32'd1);

        // Conflict on index 3: 3 and 19 evict each other.
        ldr(8'd3, 0, 1'b0, d, lat);
        chk("ld3_data", 32'(d), 32'hA6);
        b = rd_bursts; ldr(8'd19, 0, 1'b0, d, lat);
        chk("ld19_data", 32'(d), 32'hB6);
        chk("ld19_fills", 32'(rd_bursts - b), 32'd1);
        b = rd_bursts; ldr(8'd3, 0, 1'b0, d, lat);
        chk("ld3_again_data", 32'(d), 32'hA6);
        chk("ld3_again_fills", 32'(rd_bursts - b), 32'd1);

        // Flush during a pending fill: data still returned, line then invalid.
        b = rd_bursts; ldr(8'd2, 0, 1'b1, d, lat);
        chk("flfill_data", 32'(d), 32'd55);
        chk("flfill_fills", 32'(rd_bursts - b), 32'd1);
        b = rd_bursts; ldr(8'd2, 0, 1'b0, d, lat);
        chk("flfill_next_fills", 32'(rd_bursts - b), 32'd1);
        chk("flfill_next_data", 32'(d), 32'd55);

        // Request held 4 cycles past ready: exactly one pulse.
        ldr(8'd2, 4, 1'b0, d, lat);
        chk("hold_lat", 32'(lat), 32'd1);
        chk("hold_extra", 32'(extra), 32'd0);

        // Flush while idle.
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        b = rd_bursts; ldr(8'd2, 0, 1'b0, d, lat);
        chk("flidle_fills", 32'(rd_bursts - b), 32'd1);
`ifdef DCACHE_STATS_EN
        chk("stat_hits_fl", 32'(hit_count), 32'd0);
        chk("stat_miss_fl", 32'(miss_count), 32'd1);
`endif

        // Reset in the middle of a fill.
        ldr(8'd9, 0, 1'b0, d, lat);
        chk("ld9_data", 32'(d), 32'hAC);
        @(negedge clk);
        lsu_read_valid = 1'b1; lsu_read_address = 8'd17;
        n = 0;
        while (!mem_read_valid && n < 20) begin @(negedge clk); n++; end
        chk("rstfill_seen", 32'(mem_read_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstfill_mrv", 32'(mem_read_valid), 32'd0);
        chk("rstfill_rdy", 32'(lsu_read_ready), 32'd0);
        @(negedge clk);
        lsu_read_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        b = rd_bursts; ldr(8'd9, 0, 1'b0, d, lat);
        chk("rst_ld9_fills", 32'(rd_bursts - b), 32'd1);
        chk("rst_ld9_data", 32'(d), 32'hAC);

        // Simultaneous load and store to 0: the store goes first.
        @(negedge clk);
        lsu_read_valid = 1'b1;  lsu_read_address = 8'd0;
        lsu_write_valid = 1'b1; lsu_write_address = 8'd0; lsu_write_data = 8'd77;
        n = 0; got = 1'b0; rd_early = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk); n++;
            if (lsu_read_ready) rd_early = 1'b1;
            if (lsu_write_ready) got = 1'b1;
        end
        chk("prio_wr_done", 32'(got), 32'd1);
        chk("prio_rd_early", 32'(rd_early), 32'd0);
        lsu_write_valid = 1'b0;
        n = 0; got = 1'b0; d = '0;
        while (!got && n < 60) begin
            @(negedge clk); n++;
            if (lsu_read_ready) begin got = 1'b1; d = lsu_read_data; end
        end
        chk("prio_rd_done", 32'(got), 32'd1);
        chk("prio_rd_data", 32'(d), 32'd77);
        lsu_read_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
